// File: rtl/coupling_array_sequencer.sv
// coupling_array_sequencer: loads one coupling weight per cell of an N x N
// ring-oscillator array, holds the array disabled while it settles, enables
// it for a programmed window, then captures the synchronized phases.
// Optional feature macro: WEIGHT_CLAMP_EN (clamp out-of-range weights, flag err).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, run_cycles  job trigger and oscillation window length
//   wr_valid/wr_ready  weight stream handshake, wr_data = weight of next cell
//   weights            registered weight bus, cell k at [k*WW +: WW]
//   osc_en, osc_phase  oscillator enable out, raw oscillator phases in
//   spins, spins_valid captured phases and one-cycle update pulse
//   busy, err          job in progress, sticky out-of-range weight flag
module coupling_array_sequencer #(
    parameter int N             = 4,
    parameter int NUM_WEIGHTS   = 5,
    parameter int WW            = $clog2(NUM_WEIGHTS),
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       run_cycles,
    input  logic              wr_valid,
    input  logic [WW-1:0]     wr_data,
    output logic              wr_ready,
    output logic [N*N*WW-1:0] weights,
    output logic              osc_en,
    input  logic [N-1:0]      osc_phase,
    output logic [N-1:0]      spins,
    output logic              spins_valid,
    output logic              busy,
    output logic              err
);

    localparam int CELLS = N * N;
    localparam int CW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_SYNC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_tmr;
    logic [15:0]    r_run_len;
    logic [WW-1:0]  r_w [CELLS];
    logic [N-1:0]   r_sync1;
    logic [N-1:0]   r_sync2;
    logic [N-1:0]   r_spins;
    logic           r_spins_valid;
    logic [WW-1:0]  w_wdata;
    logic           w_hs;
    logic           w_last;
    logic           w_tmr_zero;
    logic           w_accept;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_hs       = wr_valid && (r_state == S_LOAD);
    assign w_last     = (r_cnt == CW'(CELLS - 1));
    assign w_tmr_zero = (r_tmr == 16'd0);

    // Outputs decode straight from the state register so that an
    // asynchronous reset drops osc_en without waiting for a clock edge.
    assign wr_ready    = (r_state == S_LOAD);
    assign osc_en      = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);
    assign spins       = r_spins;
    assign spins_valid = r_spins_valid;

`ifdef WEIGHT_CLAMP_EN
    logic w_oor;
    logic r_err;

    assign w_oor   = (int'(wr_data) >= NUM_WEIGHTS);
    assign w_wdata = w_oor ? WW'(NUM_WEIGHTS - 1) : wr_data;
    assign err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_hs && w_oor) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_wdata = wr_data;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   if (w_hs && w_last) w_next = S_SETTLE;
            S_SETTLE: if (w_tmr_zero) w_next = S_RUN;
            S_RUN:    if (w_tmr_zero) w_next = S_SYNC;
            S_SYNC:   if (w_tmr_zero) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_tmr holds "cycles left in this state minus one", reloaded on
    // every transition into a timed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_tmr         <= '0;
            r_run_len     <= 16'd1;
            r_spins       <= '0;
            r_spins_valid <= 1'b0;
            for (int k = 0; k < CELLS; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            r_spins_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_run_len <= (run_cycles == 16'd0) ? 16'd1 : run_cycles;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_w[r_cnt] <= w_wdata;
                        r_cnt      <= r_cnt + 1'b1;
                        if (w_last) r_tmr <= 16'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: r_tmr <= w_tmr_zero ? r_run_len - 16'd1 : r_tmr - 16'd1;
                S_RUN:    r_tmr <= w_tmr_zero ? 16'd1 : r_tmr - 16'd1;
                S_SYNC: begin
                    if (w_tmr_zero) begin
                        r_spins       <= r_sync2;
                        r_spins_valid <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running 2-flop synchronizer for the asynchronous phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= osc_phase;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        weights = '0;
        for (int k = 0; k < CELLS; k++) begin
            weights[k*WW +: WW] = r_w[k];
        end
    end

endmodule

// File: tb/tb_coupling_array_sequencer.sv
// tb_coupling_array_sequencer: directed bench for coupling_array_sequencer
// with N=4, NUM_WEIGHTS=5, SETTLE_CYCLES=4.
module tb_coupling_array_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] run_cycles;
    logic        wr_valid;
    logic [2:0]  wr_data;
    logic        wr_ready;
    logic [47:0] weights;
    logic        osc_en;
    logic [3:0]  osc_phase;
    logic [3:0]  spins;
    logic        spins_valid;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  vals [16];
    logic [47:0] exp_w;

    coupling_array_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .run_cycles  (run_cycles),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .weights     (weights),
        .osc_en      (osc_en),
        .osc_phase   (osc_phase),
        .spins       (spins),
        .spins_valid (spins_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_exp;
        exp_w = '0;
        for (int k = 0; k < 16; k++) begin
            exp_w[k*3 +: 3] = vals[k];
        end
    endtask

    task automatic do_start(input logic [15:0] rc);
        start      = 1'b1;
        run_cycles = rc;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(wr_ready), 64'd1);
    endtask

    task automatic load_all;
        for (int k = 0; k < 16; k++) begin
            wr_valid = 1'b1;
            wr_data  = vals[k];
            check("load_ready", 64'(wr_ready), 64'd1);
            tick();
        end
        wr_valid = 1'b0;
        check("load_done_ready", 64'(wr_ready), 64'd0);
    endtask

    // Starts in the cycle after the last write; ends in the spins_valid cycle.
    task automatic measure(input int exp_settle, input int exp_high);
        int n;
        n = 0;
        while (!osc_en && n < 200) begin
            n++;
            tick();
        end
        check("settle_len", 64'(n), 64'(exp_settle));
        n = 0;
        while (osc_en && n < 200) begin
            n++;
            tick();
        end
        check("run_len", 64'(n), 64'(exp_high));
        n = 0;
        while (!spins_valid && n < 20) begin
            n++;
            tick();
        end
        check("sync_len", 64'(n), 64'd2);
        check("valid_busy", 64'(busy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        run_cycles = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        osc_phase  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_weights", 64'(weights), 64'd0);
        check("rst_osc_en", 64'(osc_en), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd0);
        check("rst_spins", 64'(spins), 64'd0);
        check("rst_valid", 64'(spins_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        wr_valid = 1'b1;
        wr_data  = 3'd3;
        tick();
        tick();
        check("idle_ready", 64'(wr_ready), 64'd0);
        check("idle_weights", 64'(weights), 64'd0);

        // Full job, wr_valid held high throughout.
        for (int k = 0; k < 16; k++) vals[k] = 3'(k % 5);
        pack_exp();
        osc_phase = 4'b0110;
        wr_data   = vals[0];
        do_start(16'd10);
        load_all();
        check("job1_weights", 64'(weights), 64'(exp_w));
        measure(4, 10);
        check("job1_spins", 64'(spins), 64'h6);
        check("job1_valid", 64'(spins_valid), 64'd1);
        tick();
        check("job1_valid_low", 64'(spins_valid), 64'd0);
        check("job1_busy_low", 64'(busy), 64'd0);

        // Gapped writes, stray start in LOAD, run_cycles=0.
        for (int k = 0; k < 16; k++) vals[k] = 3'((k * 3 + 1) % 5);
        pack_exp();
        osc_phase = 4'b1010;
        do_start(16'd0);
        for (int i = 0; i < 31; i++) begin
            wr_valid = (i % 2 == 0);
            if (i % 2 == 0) wr_data = vals[i / 2];
            start = (i == 5);
            check("bp_ready", 64'(wr_ready), 64'd1);
            tick();
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        check("bp_done_ready", 64'(wr_ready), 64'd0);
        check("bp_weights", 64'(weights), 64'(exp_w));
        measure(4, 1);
        check("bp_spins", 64'(spins), 64'hA);
        tick();
        check("bp_busy_low", 64'(busy), 64'd0);

        // Out-of-range weight on cell 5.
        for (int k = 0; k < 16; k++) vals[k] = 3'd1;
        vals[5] = 3'd7;
        do_start(16'd2);
        check("clamp_err_start", 64'(err), 64'd0);
        load_all();
`ifdef WEIGHT_CLAMP_EN
        check("clamp_cell5", 64'(weights[15 +: 3]), 64'd4);
        check("clamp_err", 64'(err), 64'd1);
`else
        check("clamp_cell5", 64'(weights[15 +: 3]), 64'd7);
        check("clamp_err", 64'(err), 64'd0);
`endif
        check("clamp_cell4", 64'(weights[12 +: 3]), 64'd1);
        measure(4, 2);
        tick();
`ifdef WEIGHT_CLAMP_EN
        check("clamp_err_sticky", 64'(err), 64'd1);
`else
        check("clamp_err_sticky", 64'(err), 64'd0);
`endif

        // Reset three cycles into RUN.
        do_start(16'd20);
        check("next_start_err", 64'(err), 64'd0);
        for (int k = 0; k < 16; k++) vals[k] = 3'd2;
        load_all();
        begin
            int n;
            n = 0;
            while (!osc_en && n < 200) begin
                n++;
                tick();
            end
            check("mid_settle_len", 64'(n), 64'd4);
        end
        repeat (3) tick();
        check("mid_osc_before", 64'(osc_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_osc_en", 64'(osc_en), 64'd0);
        check("mid_weights", 64'(weights), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_ready", 64'(wr_ready), 64'd0);
        check("mid_spins", 64'(spins), 64'd0);
        repeat (2) begin
            tick();
            check("mid_valid", 64'(spins_valid), 64'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("post_valid", 64'(spins_valid), 64'd0);
            check("post_busy", 64'(busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coupling_array_sequencer.md
# coupling_array_sequencer

Sequencer for an N×N array of coupled ring-oscillator cells. Streams one weight per cell into an internal weight register file, holds the oscillators disabled while weights are loaded, releases them for a programmed number of clock cycles, then synchronizes and captures the oscillator phases as the spin result. It sits between the host/config interface and the oscillator array. It replaces free-running weight wires with registered, sequenced programming.

## Interface
- N, 4, oscillators per side; array holds N*N cells
- NUM_WEIGHTS, 5, distinct coupling levels per cell
- WW, $clog2(NUM_WEIGHTS), weight field width
- SETTLE_CYCLES, 4, cycles osc_en stays low after the last weight write before the run starts (minimum 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load/run/sample job
- run_cycles  in  16  oscillation window length in clk cycles; sampled on accepted start
- wr_valid  in  1  weight word valid
- wr_data  in  WW  weight for the current cell (row-major, cell 0 = row 0 col 0)
- wr_ready  out  1  weight word accepted when wr_valid && wr_ready
- weights  out  N*N*WW  registered weight bus; cell k occupies bits [k*WW +: WW]
- osc_en  out  1  oscillator enable to the array
- osc_phase  in  N  raw asynchronous oscillator outputs
- spins  out  N  captured, synchronized phases
- spins_valid  out  1  one-cycle pulse when spins updates
- busy  out  1  high in every state except IDLE
- err  out  1  sticky out-of-range weight flag (see Configuration)

## Operation
- States: IDLE, LOAD, SETTLE, RUN, SYNC, DONE.
- IDLE: wr_ready=0, osc_en=0. On start: latch run_cycles (0 is treated as 1), clear err, set cell counter to 0, go to LOAD.
- LOAD: wr_ready=1. Each handshake writes wr_data into weights[cnt] and increments cnt. On the handshake with cnt==N*N-1, go to SETTLE with wr_ready low the next cycle. wr_valid without wr_ready is ignored. There is no timeout; LOAD waits indefinitely.
- SETTLE: count SETTLE_CYCLES cycles, then go to RUN.
- RUN: osc_en=1 for exactly the latched run_cycles cycles, then go to SYNC with osc_en=0.
- osc_phase passes through a 2-flop synchronizer that is always running.
- SYNC: wait 2 cycles for the synchronizer to flush, then capture the synchronizer output into spins, pulse spins_valid, and go to DONE.
- DONE: one cycle, then IDLE.
- start outside IDLE is ignored. It does not restart and is not queued.
- weights holds its contents across jobs and is only overwritten cell by cell during LOAD.

## Timing
- Reset values: weights=0, osc_en=0, wr_ready=0, spins=0, spins_valid=0, busy=0, err=0, state IDLE.
- start in cycle t: busy=1 and wr_ready=1 from t+1.
- Last handshake in cycle w: osc_en=1 from w+1+SETTLE_CYCLES, for run_cycles cycles.
- osc_en falling in cycle f: spins and spins_valid valid in f+2. busy falls at f+3.
- Total job latency after load = SETTLE_CYCLES + run_cycles + 3 cycles.
- Reset asserted mid-job: osc_en drops immediately (asynchronous), all outputs return to reset values, and the partially loaded weights are cleared.

## Configuration
- WEIGHT_CLAMP_EN defined: a wr_data value ≥ NUM_WEIGHTS is stored as NUM_WEIGHTS-1 and sets err. err stays set until the next accepted start.
- WEIGHT_CLAMP_EN undefined: wr_data is stored unmodified and err is tied to 0.

## Test plan
- Reset/idle: deassert rst_n with N=4, no start → all outputs 0; wr_valid=1 gives wr_ready=0 and weights unchanged.
- Full job: start, run_cycles=10, stream 16 weights 0,1,2,3,4,0,… with wr_valid always high → weights[k]=k%5; osc_en high for exactly 10 cycles starting 4 cycles after the last write; spins_valid pulse 2 cycles after osc_en falls.
- Backpressure/gaps: wr_valid toggles every other cycle → 16 writes accepted in 31 cycles and all cells correct; start pulsed during LOAD → no effect.
- Edge values: run_cycles=0 → osc_en high 1 cycle. osc_phase=4'b1010 held through RUN → spins=4'b1010.
- Clamp: with WEIGHT_CLAMP_EN (WW=3), write 7 to cell 5 → weights[5]=4, err=1, cleared on next start. Without the macro → weights[5]=7, err=0.
- Reset mid-RUN: rst_n low 3 cycles into RUN → osc_en=0 in the same cycle, weights=0, state IDLE, no spins_valid.
